// File: rtl/led_command_parser.sv
// Line-based UART command parser driving a packed RGB shade bank.
// Accepts at most one byte every two cycles, echoes each accepted byte, and decodes toggle/set/all-off commands.
module led_command_parser #(
  parameter int unsigned NUM_LEDS = 3,
  parameter int unsigned SHADE_WIDTH = 8,
  parameter logic [SHADE_WIDTH-1:0] DEFAULT_SHADE = SHADE_WIDTH'(8'h11)
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset_n,
  input  logic [7:0]                          i_Data,
  input  logic                                i_Data_Ready,
  output logic                                o_Read_Data,
  output logic [7:0]                          o_TX_Data,
  output logic                                o_TX_Start,
  input  logic                                i_TX_Busy,
  output logic [NUM_LEDS*3*SHADE_WIDTH-1:0]   o_Shades,
  output logic                                o_Update,
  output logic                                o_Error
);

  localparam int unsigned HEX_DIGITS = SHADE_WIDTH / 4;
  localparam int unsigned CNT_W      = $clog2(HEX_DIGITS + 1);
  localparam int unsigned NUM_CH     = NUM_LEDS * 3;
  localparam int unsigned CH_W       = $clog2(NUM_CH);
  localparam int unsigned LED_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [7:0] C_R  = 8'h72;
  localparam logic [7:0] C_G  = 8'h67;
  localparam logic [7:0] C_B  = 8'h62;
  localparam logic [7:0] C_X  = 8'h78;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_EQ = 8'h3D;

  typedef enum logic [2:0] {
    S_COLOUR, S_NUMBER, S_EQNL, S_HEX, S_NL, S_ALLNL, S_DISCARD
  } state_t;

  state_t                 state, state_nx;
  logic                   pause;
  logic [1:0]             colour, colour_nx;
  logic [LED_W-1:0]       led, led_nx;
  logic [SHADE_WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;

  logic                   accept_c;
  logic                   hex_ok_c;
  logic [3:0]             nibble_c;
  logic                   led_ok_c;
  logic                   err_c, do_toggle_c, do_set_c, do_clear_c;
  logic [CH_W-1:0]        ch_c;
  logic [SHADE_WIDTH-1:0] cur_shade_c;

  assign accept_c = i_Data_Ready && !i_TX_Busy && !pause;
  assign led_ok_c = (i_Data >= 8'h31) && (i_Data <= 8'(48 + NUM_LEDS));
  assign ch_c     = CH_W'(32'(led) * 3 + 32'(colour));
  assign cur_shade_c = o_Shades[ch_c*SHADE_WIDTH +: SHADE_WIDTH];

  // ASCII hex digit decode
  always_comb begin
    hex_ok_c = 1'b0;
    nibble_c = 4'h0;
    if (i_Data >= 8'h30 && i_Data <= 8'h39) begin
      hex_ok_c = 1'b1;
      nibble_c = 4'(i_Data - 8'h30);
    end else if (i_Data >= 8'h61 && i_Data <= 8'h66) begin
      hex_ok_c = 1'b1;
      nibble_c = 4'(i_Data - 8'h57);
    end else if (i_Data >= 8'h41 && i_Data <= 8'h46) begin
      hex_ok_c = 1'b1;
      nibble_c = 4'(i_Data - 8'h37);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state <= S_COLOUR;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    colour_nx   = colour;
    led_nx      = led;
    acc_nx      = acc;
    cnt_nx      = cnt;
    err_c       = 1'b0;
    do_toggle_c = 1'b0;
    do_set_c    = 1'b0;
    do_clear_c  = 1'b0;
    if (accept_c && i_Data != C_CR) begin
      unique case (state)
        S_COLOUR: begin
          if (i_Data == C_R)      begin colour_nx = 2'd0; state_nx = S_NUMBER; end
          else if (i_Data == C_G) begin colour_nx = 2'd1; state_nx = S_NUMBER; end
          else if (i_Data == C_B) begin colour_nx = 2'd2; state_nx = S_NUMBER; end
          else if (i_Data == C_X) state_nx = S_ALLNL;
          else if (i_Data != C_LF) begin state_nx = S_DISCARD; err_c = 1'b1; end
        end
        S_NUMBER: begin
          if (led_ok_c) begin
            led_nx   = LED_W'(i_Data - 8'h31);
            state_nx = S_EQNL;
          end else begin
            err_c    = 1'b1;
            state_nx = (i_Data == C_LF) ? S_COLOUR : S_DISCARD;
          end
        end
        S_EQNL: begin
          if (i_Data == C_LF) begin
            do_toggle_c = 1'b1;
            state_nx    = S_COLOUR;
          end else if (i_Data == C_EQ) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = S_HEX;
          end else begin
            err_c    = 1'b1;
            state_nx = S_DISCARD;
          end
        end
        S_HEX: begin
          if (hex_ok_c) begin
            acc_nx = (acc << 4) | SHADE_WIDTH'(nibble_c);
            cnt_nx = cnt + CNT_W'(1);
            if (cnt_nx == CNT_W'(HEX_DIGITS)) state_nx = S_NL;
          end else begin
            err_c    = 1'b1;
            state_nx = (i_Data == C_LF) ? S_COLOUR : S_DISCARD;
          end
        end
        S_NL: begin
          if (i_Data == C_LF) begin
            do_set_c = 1'b1;
            state_nx = S_COLOUR;
          end else begin
            err_c    = 1'b1;
            state_nx = S_DISCARD;
          end
        end
        S_ALLNL: begin
          if (i_Data == C_LF) begin
            do_clear_c = 1'b1;
            state_nx   = S_COLOUR;
          end else begin
            err_c    = 1'b1;
            state_nx = S_DISCARD;
          end
        end
        S_DISCARD: if (i_Data == C_LF) state_nx = S_COLOUR;
        default:   state_nx = S_COLOUR;
      endcase
    end
  end

  // Command latches, echo path and shade bank
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      pause       <= 1'b0;
      colour      <= '0;
      led         <= '0;
      acc         <= '0;
      cnt         <= '0;
      o_Read_Data <= 1'b0;
      o_TX_Start  <= 1'b0;
      o_TX_Data   <= '0;
      o_Update    <= 1'b0;
      o_Error     <= 1'b0;
      o_Shades    <= '0;
    end else begin
      pause       <= accept_c;
      colour      <= colour_nx;
      led         <= led_nx;
      acc         <= acc_nx;
      cnt         <= cnt_nx;
      o_Read_Data <= accept_c;
      o_TX_Start  <= accept_c;
      if (accept_c) o_TX_Data <= i_Data;
      o_Error     <= err_c;
      o_Update    <= do_toggle_c | do_set_c | do_clear_c;
      if (do_clear_c)
        o_Shades <= '0;
      else if (do_toggle_c)
        o_Shades[ch_c*SHADE_WIDTH +: SHADE_WIDTH] <= (cur_shade_c != '0) ? '0 : DEFAULT_SHADE;
      else if (do_set_c)
        o_Shades[ch_c*SHADE_WIDTH +: SHADE_WIDTH] <= acc;
    end
  end

endmodule

// File: tb/tb_led_command_parser.sv
// Directed bench for led_command_parser: command lines, errors, stalls and reset.
module tb_led_command_parser;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n;
  logic [7:0]  i_Data;
  logic        i_Data_Ready;
  logic        o_Read_Data;
  logic [7:0]  o_TX_Data;
  logic        o_TX_Start;
  logic        i_TX_Busy;
  logic [71:0] o_Shades;
  logic        o_Update;
  logic        o_Error;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0, err_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int u0, e0, r0, gap;
  logic [71:0] exp_shades;

  led_command_parser #(.NUM_LEDS(3), .SHADE_WIDTH(8), .DEFAULT_SHADE(8'h11)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Data(i_Data), .i_Data_Ready(i_Data_Ready),
    .o_Read_Data(o_Read_Data), .o_TX_Data(o_TX_Data), .o_TX_Start(o_TX_Start),
    .i_TX_Busy(i_TX_Busy), .o_Shades(o_Shades), .o_Update(o_Update), .o_Error(o_Error)
  );

  always #5 i_Clock = ~i_Clock;

  // Pulse counters sampled mid-cycle
  always @(negedge i_Clock) begin
    if (o_Update) upd_cnt++;
    if (o_Error) err_cnt++;
    if (o_Read_Data) rd_cnt++;
    if (o_Update && o_Error) both_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a byte and wait for its pop; returns cycles waited
  task automatic send_byte(input logic [7:0] b, output int n);
    n = 0;
    i_Data = b;
    i_Data_Ready = 1'b1;
    while (1) begin
      @(posedge i_Clock); #1;
      n++;
      if (o_Read_Data) break;
      if (n > 50) break;
    end
    chk("pop_seen", 128'(o_Read_Data), 128'd1);
    chk("echo_data", 128'(o_TX_Data), 128'(b));
    chk("echo_start", 128'(o_TX_Start), 128'd1);
  endtask

  task automatic send_str(input string s);
    int n;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], n);
  endtask

  task automatic idle();
    i_Data_Ready = 1'b0;
    repeat (3) @(posedge i_Clock);
    #1;
  endtask

  task automatic line(input string s);
    int n;
    u0 = upd_cnt; e0 = err_cnt; r0 = rd_cnt;
    send_str(s);
    send_byte(8'h0A, n);
    idle();
  endtask

  task automatic expect_counts(input string tag, input int du, input int de);
    chk({tag, "_upd"}, 128'(upd_cnt - u0), 128'(du));
    chk({tag, "_err"}, 128'(err_cnt - e0), 128'(de));
  endtask

  initial begin
    int n;
    i_Reset_n = 1'b0; i_Data = 8'h00; i_Data_Ready = 1'b0; i_TX_Busy = 1'b0;
    repeat (3) @(posedge i_Clock);
    #1;
    chk("rst_shades", 128'(o_Shades), 128'd0);
    chk("rst_strobes", 128'({o_Read_Data, o_TX_Start, o_Update, o_Error}), 128'd0);
    chk("rst_txdata", 128'(o_TX_Data), 128'd0);
    @(negedge i_Clock); i_Reset_n = 1'b1;
    repeat (2) @(posedge i_Clock);
    #1;

    line("r1");
    chk("toggle_on", 128'(o_Shades), 128'h11);
    expect_counts("toggle_on", 1, 0);
    chk("toggle_on_echo", 128'(rd_cnt - r0), 128'd3);
    line("r1");
    chk("toggle_off", 128'(o_Shades), 128'd0);
    expect_counts("toggle_off", 1, 0);

    line("b3=A5");
    chk("set_b3", 128'(o_Shades[71:64]), 128'hA5);
    expect_counts("set_b3", 1, 0);

    u0 = upd_cnt; e0 = err_cnt; r0 = rd_cnt;
    send_str("g2=7f");
    send_byte(8'h0D, n);
    send_byte(8'h0A, n);
    idle();
    chk("set_g2_cr", 128'(o_Shades[39:32]), 128'h7F);
    expect_counts("set_g2_cr", 1, 0);
    chk("set_g2_echo", 128'(rd_cnt - r0), 128'd7);

    line("");
    expect_counts("empty_line", 0, 0);
    line("r4");
    expect_counts("bad_led", 0, 1);
    line("q1");
    expect_counts("bad_colour", 0, 1);
    line("r");
    expect_counts("nl_in_number", 0, 1);
    line("g1");
    chk("recover_g1", 128'(o_Shades[15:8]), 128'h11);
    expect_counts("recover_g1", 1, 0);

    line("r1=A");
    expect_counts("few_digits", 0, 1);
    line("r1=ABC");
    expect_counts("many_digits", 0, 1);
    exp_shades = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h11, 8'h00};
    chk("bank_before_x", 128'(o_Shades), 128'(exp_shades));

    line("x");
    chk("all_off", 128'(o_Shades), 128'd0);
    expect_counts("all_off", 1, 0);
    line("x");
    expect_counts("all_off_again", 1, 0);

    line("r2=3C");
    chk("set_r2", 128'(o_Shades[31:24]), 128'h3C);

    // Transmitter busy stalls acceptance
    r0 = rd_cnt;
    i_TX_Busy = 1'b1; i_Data = 8'h62; i_Data_Ready = 1'b1;
    repeat (10) @(posedge i_Clock);
    #1;
    chk("busy_stall", 128'(rd_cnt - r0), 128'd0);
    @(negedge i_Clock); i_TX_Busy = 1'b0;
    u0 = upd_cnt; e0 = err_cnt;
    send_byte(8'h62, n);
    send_byte(8'h32, gap);
    chk("rate_gap1", 128'(gap), 128'd2);
    send_byte(8'h0A, gap);
    chk("rate_gap2", 128'(gap), 128'd2);
    idle();
    chk("after_stall_b2", 128'(o_Shades[47:40]), 128'h11);
    expect_counts("after_stall_b2", 1, 0);

    // Reset in the middle of a set command
    send_str("b2=3");
    i_Data_Ready = 1'b0;
    @(negedge i_Clock); i_Reset_n = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    chk("midline_rst_shades", 128'(o_Shades), 128'd0);
    @(negedge i_Clock); i_Reset_n = 1'b1;
    repeat (2) @(posedge i_Clock);
    #1;
    line("b2");
    chk("post_rst_b2", 128'(o_Shades), 128'(72'h11) << 40);
    expect_counts("post_rst_b2", 1, 0);

    chk("never_both", 128'(both_cnt), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=hang expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
